// File: rtl/mul_shift_if.sv
// mul_shift_if: operand/result bundle for the mul_shift multiplier.
//   a_in, b_in  : WIDTH-bit multiplicand and multiplier (master -> slave)
//   x_ready     : one-cycle start strobe (master -> slave)
//   y_out       : 2*WIDTH-bit registered product (slave -> master)
//   y_ready     : one-cycle completion strobe (slave -> master)
//   busy        : high while the multiplier is not idle (slave -> master)
interface mul_shift_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic               x_ready;
    logic [2*WIDTH-1:0] y_out;
    logic               y_ready;
    logic               busy;

    modport master (
        output a_in, b_in, x_ready,
        input  y_out, y_ready, busy
    );

    modport slave (
        input  a_in, b_in, x_ready,
        output y_out, y_ready, busy
    );
endinterface

// File: rtl/mul_shift.sv
// mul_shift: sequential WIDTH x WIDTH unsigned shift-and-add multiplier.
// One multiplier bit is consumed per clock; the 2*WIDTH-bit product is
// presented on y_out with a one-cycle y_ready strobe and held afterwards.
// Ports:
//   clk         : rising-edge clock
//   rst         : synchronous, active-high reset
//   bus (slave) : a_in, b_in, x_ready in; y_out, y_ready, busy out
// Configuration:
//   MUL_SHIFT_EARLY_TERM_EN : when defined, the iteration loop stops as soon
//   as no multiplier bits remain (minimum one iteration). Products are
//   identical; only latency changes.
module mul_shift #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    mul_shift_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   y_out_q, y_out_d;
    logic            y_ready_q, y_ready_d;
    logic            busy_q, busy_d;

    logic [PW-1:0]   sum;
    logic            last;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        y_out_d   = y_out_q;
        y_ready_d = y_ready_q;
        busy_d    = busy_q;

        // Accumulator value after this iteration; also the final product
        // when this is the terminating iteration.
        sum  = acc_q + (b_q[0] ? a_q : '0);
        last = (cnt_q == CW'(WIDTH - 1));
`ifdef MUL_SHIFT_EARLY_TERM_EN
        last = last || ((b_q >> 1) == '0);
`else
        last = last;
`endif

        case (state_q)
            IDLE: begin
                y_ready_d = 1'b0;
                busy_d    = 1'b0;
                if (bus.x_ready) begin
                    a_d     = PW'(bus.a_in);
                    b_d     = bus.b_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = sum;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    y_out_d   = sum;
                    y_ready_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                y_ready_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                y_ready_d = 1'b0;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            y_out_q   <= '0;
            y_ready_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            y_out_q   <= y_out_d;
            y_ready_q <= y_ready_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.y_out   = y_out_q;
    assign bus.y_ready = y_ready_q;
    assign bus.busy    = busy_q;
endmodule

// File: tb/tb_mul_shift.sv
// tb_mul_shift: directed scoreboard bench for mul_shift.
// Stimulus pushes the expected product and the cycle in which y_ready must
// be observed; an independent monitor pops on every y_ready.
module tb_mul_shift;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_shift_if #(.WIDTH(WIDTH)) bus ();

    mul_shift #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] prod;
        int          obs;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Negedge cycle index (relative to E0) at which y_ready is seen high.
    function automatic int iters(input logic [7:0] b);
`ifdef MUL_SHIFT_EARLY_TERM_EN
        int n = 1;
        for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
        return n;
`else
        return 8;
`endif
    endfunction

    // Monitor: every y_ready strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bus.y_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_y_ready actual=1 required=0 (cyc %0d y_out=%0d)", cyc, bus.y_out);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_prod"}, 32'(bus.y_out), 32'(mon_e.prod));
                chk({mon_e.name, "_lat"}, 32'(cyc), 32'(mon_e.obs));
            end
        end
    end

    // Called just after a negedge; returns E0 as a cyc value.
    task automatic start(input logic [7:0] a, input logic [7:0] b,
                         input logic [15:0] prod, input string nm, output int e0);
        exp_t e;
        bus.a_in    = a;
        bus.b_in    = b;
        bus.x_ready = 1'b1;
        e0 = cyc + 1;
        e.prod = prod;
        e.obs  = e0 + iters(b);
        e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        bus.x_ready = 1'b0;
    endtask

    task automatic drain(input string nm);
        int budget = 40;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout actual=%0d pending required=0", nm, sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    initial begin
        int e0;
        rst         = 1'b1;
        bus.a_in    = '0;
        bus.b_in    = '0;
        bus.x_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_y_out", 32'(bus.y_out), 0);
        chk("reset_y_ready", 32'(bus.y_ready), 0);
        chk("reset_busy", 32'(bus.busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // 13 * 15, start one cycle after reset release
        start(8'd13, 8'd15, 16'd195, "m13x15", e0);
        drain("m13x15");
        chk("hold_195", 32'(bus.y_out), 195);
        chk("hold_y_ready_low", 32'(bus.y_ready), 0);

        // 255 * 255 with busy window
        start(8'd255, 8'd255, 16'hFE01, "m255x255", e0);
        chk("busy_E0", 32'(bus.busy), 1);
        wait_until(e0 + iters(8'd255));
        chk("busy_last", 32'(bus.busy), 1);
        @(negedge clk);
        chk("busy_cleared", 32'(bus.busy), 0);
        drain("m255x255");

        // zero operands
        start(8'd0, 8'd200, 16'd0, "m0x200", e0);
        drain("m0x200");
        start(8'd77, 8'd0, 16'd0, "m77x0", e0);
        drain("m77x0");

        // second start during CALC is ignored; start at E10 accepted
        start(8'd3, 8'd5, 16'd15, "m3x5", e0);
        wait_until(e0 + 3);
        bus.a_in    = 8'd9;
        bus.b_in    = 8'd9;
        bus.x_ready = 1'b1;
        @(negedge clk);
        bus.x_ready = 1'b0;
        wait_until(e0 + 9);
        start(8'd9, 8'd9, 16'd81, "m9x9", e0);
        drain("m9x9");

        // reset mid-operation at E5, then restart on the following edge
        bus.a_in    = 8'd100;
        bus.b_in    = 8'd100;
        bus.x_ready = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        bus.x_ready = 1'b0;
        wait_until(e0 + 4);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_y_out", 32'(bus.y_out), 0);
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_y_ready", 32'(bus.y_ready), 0);
        rst = 1'b0;
        start(8'd100, 8'd100, 16'd10000, "m100x100", e0);
        drain("m100x100");

        // rst and x_ready on the same edge: start dropped
        rst         = 1'b1;
        bus.a_in    = 8'd7;
        bus.b_in    = 8'd7;
        bus.x_ready = 1'b1;
        @(negedge clk);
        rst         = 1'b0;
        bus.x_ready = 1'b0;
        chk("rst_x_busy", 32'(bus.busy), 0);
        @(negedge clk);
        chk("rst_x_busy_after", 32'(bus.busy), 0);
        chk("rst_x_y_out", 32'(bus.y_out), 0);
        repeat (12) @(negedge clk);
        chk("final_queue_empty", 32'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
